noc_inject_port: RTL and testbench
==================================

// Module: noc_inject_port
// PURPOSE
//  Downstream consumer of the dataout buffer stage. Captures its 20-bit flit stream (data + out_valid,
//  no backpressure) into a FWFT FIFO and presents it to the router local input port under valid/ready.
//  Checks packet framing on departing flits, counts completed packets, and flags overflow and framing errors.
// PARAMETERS
//  DEPTH        32  FIFO entries (power of 2, >= 2); one full 30-flit packet fits without loss
//  AW           5   log2(DEPTH)
//  MAX_PKT_LEN  30  max flits per packet, head and tail inclusive
// PORTS
//  clk         in   1        system clock, rising edge
//  RST         in   1        asynchronous, active-low reset
//  in_data     in   20       flit from upstream buffer; [19:18] type: 10 head, 00 body, 01 tail, 11 single
//  in_valid    in   1        in_data is valid this cycle; upstream cannot stall
//  flit_out    out  20       flit to router; equals FIFO head entry
//  flit_valid  out  1        FIFO not empty
//  flit_ready  in   1        router accepts flit_out this cycle
//  fifo_count  out  AW+1     current occupancy, 0..DEPTH
//  overflow    out  1        sticky: an input flit was dropped
//  frame_err   out  1        sticky: framing or length violation seen on output side
//  err_clr     in   1        synchronous clear of overflow and frame_err
//  pkt_sent    out  16       completed packets sent (tail or single popped); wraps 0xFFFF->0
//  busy        out  1        framing FSM in PKT state
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; rd/wr pointers 0; FSM IDLE; pkt_len 0. Mid-operation reset discards
//   FIFO contents and partial packet with no error flagged.
//  push = in_valid && (fifo_count < DEPTH || pop); pop = flit_valid && flit_ready.
//  Push and pop in the same cycle are both performed; fifo_count unchanged. A push when full with no pop
//   drops in_data and sets overflow on the next edge.
//  Latency: a flit pushed into an empty FIFO at edge N appears on flit_out with flit_valid=1 after edge N
//   (1 cycle). With flit_ready held high, throughput is 1 flit/cycle.
//  flit_out and flit_valid must hold stable while flit_valid=1 && flit_ready=0.
//  Pointers are AW bits wide and wrap DEPTH-1 -> 0. fifo_count saturates at neither end; overflow and
//   underflow are prevented by construction.
//  Framing FSM advances only on pop; flits are always forwarded, never filtered:
//   IDLE: head   -> PKT, pkt_len=1
//         single -> IDLE, pkt_sent+1
//         body or tail -> IDLE, frame_err=1
//   PKT:  body -> pkt_len+1; if the new length > MAX_PKT_LEN, set frame_err and stay in PKT
//         tail -> IDLE, pkt_sent+1; if pkt_len+1 > MAX_PKT_LEN, set frame_err
//         head -> frame_err=1, restart with pkt_len=1
//         single -> frame_err=1, IDLE, pkt_sent+1
//  err_clr has priority over a same-cycle error set: the flags read 0 afterwards.
//  busy = (state == PKT).
// TESTING
//  1. Reset, push a 30-flit packet (head, 28 body, tail) with flit_ready=1 -> 30 flits out in order,
//     pkt_sent=1, frame_err=0, fifo_count peaks at 1, busy low after the tail.
//  2. flit_ready=0 during a 30-flit burst, then 1 -> fifo_count=30, 30 flits out in order, no overflow.
//  3. flit_ready=0, push 34 flits -> fifo_count=32, overflow=1, flits 33-34 dropped, first 32 delivered.
//  4. FIFO full, in_valid=1 and flit_ready=1 together for 5 cycles -> fifo_count stays 32, no overflow.
//  5. Send body from IDLE, then head-head-tail, then a 31-flit packet -> frame_err=1 after each case
//     (err_clr between cases); pkt_sent increments once per tail or single.
//  6. Assert RST low mid-packet at fifo_count=10 -> every output 0 next cycle; after release a fresh
//     packet is delivered cleanly.

Source files
------------

// File: rtl/noc_inject_port.sv
// Local injection port: captures a non-stallable 20-bit flit stream into a FWFT FIFO, hands it to the
// router under valid/ready, and checks packet framing on the departing flits.
module noc_inject_port #(
  parameter int DEPTH       = 32,
  parameter int AW          = 5,
  parameter int MAX_PKT_LEN = 30
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [19:0]   in_data,
  input  logic          in_valid,
  output logic [19:0]   flit_out,
  output logic          flit_valid,
  input  logic          flit_ready,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          frame_err,
  input  logic          err_clr,
  output logic [15:0]   pkt_sent,
  output logic          busy
);

  localparam int LW = $clog2(MAX_PKT_LEN + 2);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LEN_SAT  = LW'(MAX_PKT_LEN + 1);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {S_IDLE, S_PKT} state_e;

  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d, len_inc;
  logic          overflow_q, overflow_d, frame_err_q, frame_err_d, ferr_set;
  logic [15:0]   pkt_sent_q, pkt_sent_d;
  logic [19:0]   head_flit;
  logic          push, pop;

  assign head_flit = mem_q[rd_ptr_q];
  assign pop       = (count_q != '0) && flit_ready;
  // A pop frees the slot this push needs, so a full FIFO still accepts when draining.
  assign push      = in_valid && ((count_q != FULL_CNT) || pop);

  // NOTE: storage carries no reset; validity is tracked by count_q, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    pkt_len_d  = pkt_len_q;
    pkt_sent_d = pkt_sent_q;
    ferr_set   = 1'b0;
    len_inc    = (pkt_len_q == LEN_SAT) ? LEN_SAT : pkt_len_q + LW'(1);

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (pop) begin
      unique case (state_q)
        S_IDLE: begin
          unique case (head_flit[19:18])
            T_HEAD:   begin state_d = S_PKT; pkt_len_d = LW'(1); end
            T_SINGLE: pkt_sent_d = pkt_sent_q + 16'd1;
            default:  ferr_set = 1'b1;
          endcase
        end
        S_PKT: begin
          unique case (head_flit[19:18])
            T_BODY: begin
              pkt_len_d = len_inc;
              if (len_inc > LEN_MAX) ferr_set = 1'b1;
            end
            T_TAIL: begin
              state_d    = S_IDLE;
              pkt_sent_d = pkt_sent_q + 16'd1;
              if (len_inc > LEN_MAX) ferr_set = 1'b1;
            end
            T_HEAD: begin
              ferr_set  = 1'b1;
              pkt_len_d = LW'(1);
            end
            default: begin
              ferr_set   = 1'b1;
              state_d    = S_IDLE;
              pkt_sent_d = pkt_sent_q + 16'd1;
            end
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Clear wins over a same-cycle set so software never sees a flag it just cleared.
    overflow_d  = err_clr ? 1'b0 : (overflow_q  || (in_valid && !push));
    frame_err_d = err_clr ? 1'b0 : (frame_err_q || ferr_set);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      pkt_len_q   <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_sent_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      pkt_len_q   <= pkt_len_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      pkt_sent_q  <= pkt_sent_d;
    end
  end

  assign flit_valid = (count_q != '0);
  assign flit_out   = flit_valid ? head_flit : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign pkt_sent   = pkt_sent_q;
  assign busy       = (state_q == S_PKT);

endmodule

// File: tb/tb_noc_inject_port.sv
// Self-checking bench for noc_inject_port: random payloads driven cycle by cycle against a queue-based
// reference model of the FIFO and packet framing rules.
module tb_noc_inject_port;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [19:0] flit_out;
  logic        flit_valid;
  logic        flit_ready = 1'b0;
  logic [5:0]  fifo_count;
  logic        overflow, frame_err;
  logic        err_clr = 1'b0;
  logic [15:0] pkt_sent;
  logic        busy;

  noc_inject_port dut (
    .clk(clk), .RST(RST), .in_data(in_data), .in_valid(in_valid),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err),
    .err_clr(err_clr), .pkt_sent(pkt_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [19:0] m_q[$];
  bit          m_in_pkt;
  int          m_len;
  logic [15:0] m_sent;
  bit          m_ovf, m_ferr;
  logic [19:0] dut_out[$];
  logic [19:0] exp_out[$];

  function automatic logic [19:0] mk(input logic [1:0] t);
    logic [17:0] p;
    p = 18'($urandom);
    return {t, p};
  endfunction

  task automatic model_reset();
    m_q.delete(); m_in_pkt = 0; m_len = 0; m_sent = '0; m_ovf = 0; m_ferr = 0;
    dut_out.delete(); exp_out.delete();
  endtask

  task automatic model_pop(input logic [19:0] f);
    bit err;
    err = 0;
    if (!m_in_pkt) begin
      case (f[19:18])
        2'b10:   begin m_in_pkt = 1; m_len = 1; end
        2'b11:   m_sent++;
        default: err = 1;
      endcase
    end else begin
      case (f[19:18])
        2'b00:   begin m_len++; if (m_len > 30) err = 1; end
        2'b01:   begin if (m_len + 1 > 30) err = 1; m_sent++; m_in_pkt = 0; end
        2'b10:   begin err = 1; m_len = 1; end
        default: begin err = 1; m_in_pkt = 0; m_sent++; end
      endcase
    end
    if (err) m_ferr = 1;
  endtask

  // One clock: apply inputs, observe the departing flit mid-cycle, advance the model, settle past the edge.
  task automatic drive_cycle(input bit v, input logic [19:0] d, input bit r, input bit c);
    bit p, pu;
    in_valid = v; in_data = d; flit_ready = r; err_clr = c;
    #4;
    if (flit_valid && flit_ready) dut_out.push_back(flit_out);
    p  = (m_q.size() > 0) && r;
    pu = v && (m_q.size() < 32 || p);
    if (p) begin
      exp_out.push_back(m_q[0]);
      model_pop(m_q.pop_front());
    end
    if (pu) m_q.push_back(d);
    else if (v) m_ovf = 1;
    if (c) begin m_ovf = 0; m_ferr = 0; end
    @(posedge clk); #1;
  endtask

  task automatic compare_streams(input string name);
    n_checks++;
    if (dut_out.size() !== exp_out.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d flits, expected %0d", name, dut_out.size(), exp_out.size());
    end
    for (int i = 0; i < dut_out.size() && i < exp_out.size(); i++) begin
      n_checks++;
      if (dut_out[i] !== exp_out[i]) begin
        n_fail++;
        $display("FAIL %s flit %0d: got %h expected %h", name, i, dut_out[i], exp_out[i]);
      end
    end
    dut_out.delete(); exp_out.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    logic [46:0] all;
    all = {flit_out, flit_valid, fifo_count, overflow, frame_err, pkt_sent, busy};
    n_checks++;
    if (all !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected all zero", name, all);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #12;
    check_outputs_zero("reset_state");
    #2 RST = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_single_packet();
    int peak;
    peak = 0;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1, mk(i == 0 ? 2'b10 : (i == 29 ? 2'b01 : 2'b00)), 1, 0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    drive_cycle(0, '0, 1, 0);
    compare_streams("pkt30");
    n_checks++;
    if (peak !== 1) begin n_fail++; $display("FAIL pkt30 peak count: got %0d expected 1", peak); end
    n_checks++;
    if (pkt_sent !== 16'd1) begin n_fail++; $display("FAIL pkt30 pkt_sent: got %0d expected 1", pkt_sent); end
    n_checks++;
    if (frame_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pkt30 ferr/busy: got %b/%b expected 0/0", frame_err, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] first;
    first = mk(2'b10);
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1, i == 0 ? first : mk(i == 29 ? 2'b01 : 2'b00), 0, 0);
      n_checks++;
      if (flit_out !== first || flit_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold head: got %h/%b expected %h/1", flit_out, flit_valid, first);
      end
    end
    n_checks++;
    if (fifo_count !== 6'd30) begin n_fail++; $display("FAIL bp count: got %0d expected 30", fifo_count); end
    for (int i = 0; i < 31; i++) drive_cycle(0, '0, 1, 0);
    compare_streams("bp30");
    n_checks++;
    if (overflow !== 1'b0 || pkt_sent !== 16'd2) begin
      n_fail++; $display("FAIL bp ovf/sent: got %b/%0d expected 0/2", overflow, pkt_sent);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 34; i++) drive_cycle(1, mk(2'b11), 0, 0);
    n_checks++;
    if (fifo_count !== 6'd32 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf: got count %0d ovf %b expected 32/1", fifo_count, overflow);
    end
    for (int i = 0; i < 33; i++) drive_cycle(0, '0, 1, 0);
    n_checks++;
    if (dut_out.size() !== 32) begin n_fail++; $display("FAIL ovf delivered: got %0d expected 32", dut_out.size()); end
    compare_streams("ovf_first32");
    drive_cycle(0, '0, 0, 1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < 32; i++) drive_cycle(1, mk(2'b11), 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, mk(2'b11), 1, 0);
      n_checks++;
      if (fifo_count !== 6'd32 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL full pass: got count %0d ovf %b expected 32/0", fifo_count, overflow);
      end
    end
    for (int i = 0; i < 33; i++) drive_cycle(0, '0, 1, 0);
    compare_streams("full_pass");
    n_checks++;
    if (pkt_sent !== m_sent) begin n_fail++; $display("FAIL full pass sent: got %0d expected %0d", pkt_sent, m_sent); end
  endtask

  task automatic test_framing();
    logic [15:0] s0;
    // Body from IDLE
    drive_cycle(1, mk(2'b00), 1, 0);
    drive_cycle(0, '0, 1, 0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL body_idle ferr: got %b expected 1", frame_err); end
    drive_cycle(0, '0, 0, 1);
    // Head-head-tail
    s0 = pkt_sent;
    drive_cycle(1, mk(2'b10), 1, 0);
    drive_cycle(1, mk(2'b10), 1, 0);
    drive_cycle(1, mk(2'b01), 1, 0);
    drive_cycle(0, '0, 1, 0);
    n_checks++;
    if (frame_err !== 1'b1 || pkt_sent !== s0 + 16'd1) begin
      n_fail++; $display("FAIL hht: got ferr %b sent %0d expected 1/%0d", frame_err, pkt_sent, s0 + 16'd1);
    end
    drive_cycle(0, '0, 0, 1);
    // 31-flit packet: the tail is one too many
    s0 = pkt_sent;
    for (int i = 0; i < 31; i++) begin
      drive_cycle(1, mk(i == 0 ? 2'b10 : (i == 30 ? 2'b01 : 2'b00)), 1, 0);
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL len31 early ferr at %0d: got 1 expected 0", i); end
    end
    drive_cycle(0, '0, 1, 0);
    n_checks++;
    if (frame_err !== 1'b1 || pkt_sent !== s0 + 16'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len31: got ferr %b sent %0d busy %b expected 1/%0d/0", frame_err, pkt_sent, busy, s0 + 16'd1);
    end
    drive_cycle(0, '0, 0, 1);
    // Clear coincides with an error-causing pop
    drive_cycle(1, mk(2'b00), 0, 0);
    drive_cycle(0, '0, 1, 1);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clr priority: got %b expected 0", frame_err); end
    compare_streams("framing");
  endtask

  task automatic test_reset_mid();
    drive_cycle(1, mk(2'b10), 0, 0);
    for (int i = 0; i < 9; i++) drive_cycle(1, mk(2'b00), 0, 0);
    n_checks++;
    if (fifo_count !== 6'd10 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pre-reset: got count %0d busy %b expected 10/0", fifo_count, busy);
    end
    drive_cycle(0, '0, 1, 0);
    in_valid = 0; flit_ready = 0;
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    model_reset();
    #2 RST = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive_cycle(1, mk(i == 0 ? 2'b10 : (i == 3 ? 2'b01 : 2'b00)), 1, 0);
    drive_cycle(0, '0, 1, 0);
    compare_streams("post_reset");
    n_checks++;
    if (pkt_sent !== 16'd1 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL post reset: got sent %0d ferr %b ovf %b expected 1/0/0", pkt_sent, frame_err, overflow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 9) < 7, mk(2'($urandom)), $urandom_range(0, 9) < 5,
                  $urandom_range(0, 29) == 0);
      n_checks++;
      if (fifo_count !== 6'(m_q.size()) || flit_valid !== (m_q.size() > 0) || overflow !== m_ovf ||
          frame_err !== m_ferr || pkt_sent !== m_sent || busy !== m_in_pkt) begin
        n_fail++;
        $display("FAIL random cyc %0d: got cnt %0d v %b ovf %b ferr %b sent %0d busy %b expected %0d %b %b %b %0d %b",
                 i, fifo_count, flit_valid, overflow, frame_err, pkt_sent, busy,
                 m_q.size(), m_q.size() > 0, m_ovf, m_ferr, m_sent, m_in_pkt);
      end
      if (m_q.size() > 0) begin
        n_checks++;
        if (flit_out !== m_q[0]) begin
          n_fail++; $display("FAIL random head cyc %0d: got %h expected %h", i, flit_out, m_q[0]);
        end
      end
    end
    compare_streams("random");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_overflow();
    test_full_passthrough();
    test_framing();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
